// File: rtl/nmr_scan_sched.sv
// Scan-level scheduler: launches the bitstream controller NUM_SCANS times at a fixed start-to-start TR,
// steps the phase-cycle bank per scan and handles abort/timeout. Optional per-scan watchdog: SCAN_WDOG_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for GO; results of last series held
// ST_LAUNCH | START high, waiting for controller DONE to drop
// ST_RUN    | scan in progress, waiting for DONE to return high
// ST_TRWAIT | scan finished, waiting out the remainder of TR
// ST_KILL   | controller held in reset for two cycles
// ST_END    | one-cycle FINISHED pulse
module nmr_scan_sched #(
  parameter int SCAN_WIDTH = 16,
  parameter int TR_WIDTH   = 32,
  parameter int BANK_WIDTH = 2,
  parameter int LAUNCH_TMO = 8,
  parameter int WDOG_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  GO,
  input  logic                  ABORT,
  input  logic [SCAN_WIDTH-1:0] NUM_SCANS,
  input  logic [TR_WIDTH-1:0]   TR_CYC,
  input  logic [BANK_WIDTH-1:0] NUM_BANKS,
  input  logic [WDOG_WIDTH-1:0] WDOG_CYC,
  output logic                  BSTRM_START,
  input  logic                  BSTRM_DONE,
  output logic                  BSTRM_RST,
  output logic [BANK_WIDTH-1:0] BANK_SEL,
  output logic [SCAN_WIDTH-1:0] SCAN_IDX,
  output logic                  BUSY,
  output logic                  FINISHED,
  output logic                  ABORTED,
  output logic                  ERR,
  output logic                  OVERRUN
);

  localparam int LC_W = $clog2(LAUNCH_TMO + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_TRWAIT,
    ST_KILL,
    ST_END
  } state_t;

  state_t                state;
  logic [SCAN_WIDTH-1:0] num_scans_q;
  logic [TR_WIDTH-1:0]   tr_tgt_q;
  logic [BANK_WIDTH-1:0] bank_max_q;
  logic [TR_WIDTH-1:0]   tr_ctr;
  logic [LC_W-1:0]       launch_ctr;
  logic                  kill_ctr;
  logic                  tw_first;

  logic [TR_WIDTH-1:0]   tr_ctr_inc;
  logic                  tr_due;
  logic [BANK_WIDTH-1:0] bank_nxt;
  logic [SCAN_WIDTH-1:0] idx_nxt;
  logic                  launch_tmo;
  logic                  wdog_hit;

`ifdef SCAN_WDOG_EN
  logic [WDOG_WIDTH-1:0] wd_ctr;
  logic [WDOG_WIDTH-1:0] wd_ctr_inc;

  always_comb begin
    wd_ctr_inc = (&wd_ctr) ? wd_ctr : wd_ctr + WDOG_WIDTH'(1);
    wdog_hit   = (WDOG_CYC != '0) && (wd_ctr >= WDOG_CYC - WDOG_WIDTH'(1));
  end

  always_ff @(posedge CLK) begin
    if (!RST_N || state != ST_RUN) wd_ctr <= '0;
    else                           wd_ctr <= wd_ctr_inc;
  end
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYC;
  assign wdog_hit    = 1'b0;
`endif

  always_comb begin
    tr_ctr_inc = (&tr_ctr) ? tr_ctr : tr_ctr + TR_WIDTH'(1);
    tr_due     = tr_ctr >= tr_tgt_q;
    bank_nxt   = (BANK_SEL >= bank_max_q) ? '0 : BANK_SEL + BANK_WIDTH'(1);
    idx_nxt    = SCAN_IDX + SCAN_WIDTH'(1);
    launch_tmo = launch_ctr == LC_W'(LAUNCH_TMO - 1);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      num_scans_q <= '0;
      tr_tgt_q    <= '0;
      bank_max_q  <= '0;
      tr_ctr      <= '0;
      launch_ctr  <= '0;
      kill_ctr    <= 1'b0;
      tw_first    <= 1'b0;
      BSTRM_START <= 1'b0;
      BSTRM_RST   <= 1'b1;
      BANK_SEL    <= '0;
      SCAN_IDX    <= '0;
      BUSY        <= 1'b0;
      FINISHED    <= 1'b0;
      ABORTED     <= 1'b0;
      ERR         <= 1'b0;
      OVERRUN     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          BSTRM_RST <= 1'b0;
          // a busy controller would miss the START edge, so GO waits for DONE
          if (GO && BSTRM_DONE) begin
            num_scans_q <= NUM_SCANS;
            tr_tgt_q    <= (TR_CYC == '0) ? '0 : TR_CYC - TR_WIDTH'(1);
            bank_max_q  <= (NUM_BANKS == '0) ? '0 : NUM_BANKS - BANK_WIDTH'(1);
            SCAN_IDX    <= '0;
            BANK_SEL    <= '0;
            ABORTED     <= 1'b0;
            ERR         <= 1'b0;
            OVERRUN     <= 1'b0;
            BUSY        <= 1'b1;
            if (NUM_SCANS == '0) begin
              state    <= ST_END;
              FINISHED <= 1'b1;
            end else begin
              state       <= ST_LAUNCH;
              BSTRM_START <= 1'b1;
              tr_ctr      <= '0;
              launch_ctr  <= '0;
            end
          end
        end

        ST_LAUNCH: begin
          tr_ctr <= tr_ctr_inc;
          if (ABORT || (BSTRM_DONE && launch_tmo)) begin
            if (ABORT)                    ABORTED <= 1'b1;
            if (BSTRM_DONE && launch_tmo) ERR     <= 1'b1;
            state       <= ST_KILL;
            BSTRM_START <= 1'b0;
            BSTRM_RST   <= 1'b1;
            kill_ctr    <= 1'b0;
          end else if (!BSTRM_DONE) begin
            state       <= ST_RUN;
            BSTRM_START <= 1'b0;
          end else begin
            launch_ctr <= launch_ctr + LC_W'(1);
          end
        end

        ST_RUN: begin
          tr_ctr <= tr_ctr_inc;
          if (BSTRM_DONE) begin
            // the scan completed, so it is counted even if ABORT arrives alongside
            SCAN_IDX <= idx_nxt;
            BANK_SEL <= bank_nxt;
            if (ABORT) begin
              ABORTED   <= 1'b1;
              state     <= ST_KILL;
              BSTRM_RST <= 1'b1;
              kill_ctr  <= 1'b0;
            end else if (idx_nxt == num_scans_q) begin
              state    <= ST_END;
              FINISHED <= 1'b1;
            end else begin
              state    <= ST_TRWAIT;
              tw_first <= 1'b1;
            end
          end else if (ABORT || wdog_hit) begin
            if (ABORT)    ABORTED <= 1'b1;
            if (wdog_hit) ERR     <= 1'b1;
            state     <= ST_KILL;
            BSTRM_RST <= 1'b1;
            kill_ctr  <= 1'b0;
          end
        end

        ST_TRWAIT: begin
          tr_ctr   <= tr_ctr_inc;
          tw_first <= 1'b0;
          if (ABORT) begin
            ABORTED   <= 1'b1;
            state     <= ST_KILL;
            BSTRM_RST <= 1'b1;
            kill_ctr  <= 1'b0;
          end else if (tr_due) begin
            if (tw_first) OVERRUN <= 1'b1;
            state       <= ST_LAUNCH;
            BSTRM_START <= 1'b1;
            tr_ctr      <= '0;
            launch_ctr  <= '0;
          end
        end

        ST_KILL: begin
          if (kill_ctr) begin
            state     <= ST_END;
            BSTRM_RST <= 1'b0;
            FINISHED  <= 1'b1;
          end else begin
            kill_ctr <= 1'b1;
          end
        end

        ST_END: begin
          FINISHED <= 1'b0;
          BUSY     <= 1'b0;
          state    <= ST_IDLE;
        end

        default: begin
          state       <= ST_IDLE;
          BSTRM_START <= 1'b0;
          BUSY        <= 1'b0;
          FINISHED    <= 1'b0;
        end
      endcase
    end
  end

endmodule
